// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//   Launch-vehicle stage sequencer. Holds a programmable per-stage table and
//   walks through up to MAX_STAGES burns: for each stage it loads the stage's
//   Isp / weights / burn time onto the velocity-engine inputs, re-arms the
//   engine with a one-cycle low pulse on engine_resetb, waits for ignition_end
//   (guarded by a burn watchdog), optionally coasts, then advances.
//
// Ports
//   clk, resetb                 clock, asynchronous active-low reset
//   cfg_we/cfg_idx/cfg_*        table write port (accepted in IDLE/DONE/ABORT)
//   num_stages, launch          number of burns to fly, start pulse
//   abort                       abort request (LOAD/ARM/BURN/COAST only)
//   ignition_end                burn-complete from the velocity engine
//   engine_resetb               active-low re-arm to the velocity engine
//   specific_impulse..burntime  active stage parameters
//   stage_idx, seq_state        active stage index, FSM state
//   stage_done, cfg_err         one-cycle pulses
//   mission_done, aborted       status flags (aborted is sticky until reset)
// -----------------------------------------------------------------------------
module stage_sequencer #(
   parameter int MAX_STAGES  = 8,
   parameter int IDX_W       = 3,
   parameter int N           = 64,
   parameter int COAST_W     = 16,
   parameter int CYC_PER_SEC = 50,
   parameter int WDOG_MARGIN = 100
) (
   input  logic               clk,
   input  logic               resetb,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [N-1:0]       cfg_isp,
   input  logic [N-1:0]       cfg_init_weight,
   input  logic [N-1:0]       cfg_prop_weight,
   input  logic [N-1:0]       cfg_burntime,
   input  logic [COAST_W-1:0] cfg_coast,
   input  logic [IDX_W:0]     num_stages,
   input  logic               launch,
   input  logic               abort,
   input  logic               ignition_end,
   output logic               engine_resetb,
   output logic [N-1:0]       specific_impulse,
   output logic [N-1:0]       initial_weight,
   output logic [N-1:0]       propellant_weight,
   output logic [N-1:0]       burntime,
   output logic [IDX_W-1:0]   stage_idx,
   output logic [2:0]         seq_state,
   output logic               stage_done,
   output logic               mission_done,
   output logic               aborted,
   output logic               cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ARM   = 3'd2,
      S_BURN  = 3'd3,
      S_COAST = 3'd4,
      S_DONE  = 3'd5,
      S_ABORT = 3'd6
   } state_t;

   localparam int unsigned MAX_U = MAX_STAGES;

   // stage table
   logic [N-1:0]       r_tab_isp   [MAX_STAGES];
   logic [N-1:0]       r_tab_iw    [MAX_STAGES];
   logic [N-1:0]       r_tab_pw    [MAX_STAGES];
   logic [N-1:0]       r_tab_bt    [MAX_STAGES];
   logic [COAST_W-1:0] r_tab_coast [MAX_STAGES];

   state_t             r_state, w_next;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [IDX_W:0]     r_num, w_num_nxt;
   logic [N-1:0]       r_isp, w_isp_nxt;
   logic [N-1:0]       r_iw, w_iw_nxt;
   logic [N-1:0]       r_pw, w_pw_nxt;
   logic [N-1:0]       r_bt, w_bt_nxt;
   logic [COAST_W-1:0] r_coast, w_coast_nxt;
   logic [2*N-1:0]     r_cnt, w_cnt_nxt;
   logic [COAST_W-1:0] r_ccnt, w_ccnt_nxt;
   logic               r_eng, w_eng_nxt;
   logic               r_sdone, w_sdone_nxt;
   logic               r_mdone, w_mdone_nxt;
   logic               r_abrt, w_abrt_nxt;
   logic               r_cerr, w_cerr_nxt;
   logic               w_wr;

   logic               w_idx_ok;
   logic               w_launch_ok;
   logic               w_last;
   logic               w_cfg_open;
   logic [2*N-1:0]     w_limit;
   logic [2*N-1:0]     w_cnt_inc;
   logic               w_wdog;
   logic               w_coast_last;

   // Index range check only exists when the table does not fill the index space.
   if (MAX_STAGES < (1 << IDX_W)) begin : g_idx_chk
      assign w_idx_ok = (int'(cfg_idx) < MAX_STAGES);
   end else begin : g_idx_all
      assign w_idx_ok = 1'b1;
   end

   assign w_launch_ok  = (num_stages != '0) && (int'(num_stages) <= MAX_STAGES);
   assign w_last       = ({1'b0, r_idx} == (r_num - (IDX_W+1)'(1)));
   assign w_cfg_open   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ABORT);
   // Full-width product: no overflow for any N-bit burn time.
   assign w_limit      = ({{N{1'b0}}, r_bt} * (2*N)'(CYC_PER_SEC)) + (2*N)'(WDOG_MARGIN);
   // Counter value including the current BURN cycle.
   assign w_cnt_inc    = r_cnt + (2*N)'(1);
   assign w_wdog       = (w_cnt_inc == w_limit);
   assign w_coast_last = ((r_ccnt + COAST_W'(1)) == r_coast);

   // state register
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // next-state logic; priority abort > watchdog > ignition_end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (launch && w_launch_ok) w_next = S_LOAD;
         S_LOAD:  w_next = abort ? S_ABORT : S_ARM;
         S_ARM:   w_next = abort ? S_ABORT : S_BURN;
         S_BURN: begin
            if (abort || w_wdog)  w_next = S_ABORT;
            else if (ignition_end) begin
               if (w_last)               w_next = S_DONE;
               else if (r_coast != '0)   w_next = S_COAST;
               else                      w_next = S_LOAD;
            end
         end
         S_COAST: begin
            if (abort)             w_next = S_ABORT;
            else if (w_coast_last) w_next = S_LOAD;
         end
         S_ABORT: w_next = S_ABORT;
         default: w_next = S_IDLE;
      endcase
   end

   // output / datapath next values
   always_comb begin
      w_idx_nxt   = r_idx;
      w_num_nxt   = r_num;
      w_isp_nxt   = r_isp;
      w_iw_nxt    = r_iw;
      w_pw_nxt    = r_pw;
      w_bt_nxt    = r_bt;
      w_coast_nxt = r_coast;
      w_cnt_nxt   = r_cnt;
      w_ccnt_nxt  = r_ccnt;
      w_sdone_nxt = 1'b0;
      w_mdone_nxt = r_mdone;
      w_cerr_nxt  = 1'b0;
      w_wr        = 1'b0;
      w_abrt_nxt  = r_abrt | (w_next == S_ABORT);

      // LOAD keeps the engine line where it was: held low from IDLE,
      // high between stages, so only ARM produces the re-arm pulse.
      case (w_next)
         S_LOAD:                   w_eng_nxt = r_eng;
         S_BURN, S_COAST, S_DONE:  w_eng_nxt = 1'b1;
         default:                  w_eng_nxt = 1'b0;
      endcase

      case (r_state)
         S_IDLE, S_DONE: begin
            if (launch) begin
               if (w_launch_ok) begin
                  w_num_nxt   = num_stages;
                  w_idx_nxt   = '0;
                  w_mdone_nxt = 1'b0;
               end else begin
                  w_cerr_nxt  = 1'b1;
               end
            end
         end
         S_LOAD: begin
            w_isp_nxt   = r_tab_isp[r_idx];
            w_iw_nxt    = r_tab_iw[r_idx];
            w_pw_nxt    = r_tab_pw[r_idx];
            w_bt_nxt    = r_tab_bt[r_idx];
            w_coast_nxt = r_tab_coast[r_idx];
         end
         S_ARM: w_cnt_nxt = '0;
         S_BURN: begin
            w_cnt_nxt = w_cnt_inc;
            if ((w_next != S_BURN) && (w_next != S_ABORT)) w_sdone_nxt = 1'b1;
            if (w_next == S_LOAD)  w_idx_nxt  = r_idx + IDX_W'(1);
            if (w_next == S_COAST) w_ccnt_nxt = '0;
         end
         S_COAST: begin
            w_ccnt_nxt = r_ccnt + COAST_W'(1);
            if (w_next == S_LOAD) w_idx_nxt = r_idx + IDX_W'(1);
         end
         default: ;
      endcase

      if (w_next == S_DONE) w_mdone_nxt = 1'b1;

      if (cfg_we) begin
         if (w_cfg_open && w_idx_ok) w_wr       = 1'b1;
         else                        w_cerr_nxt = 1'b1;
      end
   end

   // registered outputs, counters and table
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_idx   <= '0;
         r_num   <= '0;
         r_isp   <= '0;
         r_iw    <= '0;
         r_pw    <= '0;
         r_bt    <= N'(1);
         r_coast <= '0;
         r_cnt   <= '0;
         r_ccnt  <= '0;
         r_eng   <= 1'b0;
         r_sdone <= 1'b0;
         r_mdone <= 1'b0;
         r_abrt  <= 1'b0;
         r_cerr  <= 1'b0;
         for (int unsigned i = 0; i < MAX_U; i++) begin
            r_tab_isp[i]   <= '0;
            r_tab_iw[i]    <= '0;
            r_tab_pw[i]    <= '0;
            r_tab_bt[i]    <= '0;
            r_tab_coast[i] <= '0;
         end
      end else begin
         r_idx   <= w_idx_nxt;
         r_num   <= w_num_nxt;
         r_isp   <= w_isp_nxt;
         r_iw    <= w_iw_nxt;
         r_pw    <= w_pw_nxt;
         r_bt    <= w_bt_nxt;
         r_coast <= w_coast_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ccnt  <= w_ccnt_nxt;
         r_eng   <= w_eng_nxt;
         r_sdone <= w_sdone_nxt;
         r_mdone <= w_mdone_nxt;
         r_abrt  <= w_abrt_nxt;
         r_cerr  <= w_cerr_nxt;
         if (w_wr) begin
            r_tab_isp[cfg_idx]   <= cfg_isp;
            r_tab_iw[cfg_idx]    <= cfg_init_weight;
            r_tab_pw[cfg_idx]    <= cfg_prop_weight;
            r_tab_bt[cfg_idx]    <= cfg_burntime;
            r_tab_coast[cfg_idx] <= cfg_coast;
         end
      end
   end

   assign engine_resetb     = r_eng;
   assign specific_impulse  = r_isp;
   assign initial_weight    = r_iw;
   assign propellant_weight = r_pw;
   assign burntime          = r_bt;
   assign stage_idx         = r_idx;
   assign seq_state         = r_state;
   assign stage_done        = r_sdone;
   assign mission_done      = r_mdone;
   assign aborted           = r_abrt;
   assign cfg_err           = r_cerr;

endmodule
